// File: rtl/ex_stage_pkg.sv
// Shared definitions for the EX stage: ALU op codes, DMEM access codes and
// the multiplier control states.
package ex_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7,
    ALU_SLT = 4'd8,
    ALU_MUL = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    DMEM_NOAC = 2'd0,
    DMEM_BYTE = 2'd1,
    DMEM_HALF = 2'd2,
    DMEM_WORD = 2'd3
  } dmem_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX instruction fields in, EX/MEM register fields out.
// An ID/EX instruction is consumed on a clock edge only when start_i & ~mem_stall_i & ~ex_stall_o;
// until then the master must hold every *_i field stable.
interface ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              RegWrite_i;
  logic              MemToReg_i;
  logic [1:0]        MemRead_i;
  logic [1:0]        MemWrite_i;
  logic [3:0]        ALUCtrl_i;
  logic              ALUSrc_i;
  logic [DATA_W-1:0] RS1data_i;
  logic [DATA_W-1:0] RS2data_i;
  logic [DATA_W-1:0] Imm_i;
  logic [REG_AW-1:0] RS1addr_i;
  logic [REG_AW-1:0] RS2addr_i;
  logic [REG_AW-1:0] RDaddr_i;

  logic              RegWrite_o;
  logic              MemToReg_o;
  logic [1:0]        MemRead_o;
  logic [1:0]        MemWrite_o;
  logic [DATA_W-1:0] ALUdata_o;
  logic [DATA_W-1:0] WriteData_o;
  logic [REG_AW-1:0] RegAddr_o;

  modport master (
    output RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, ALUCtrl_i, ALUSrc_i,
           RS1data_i, RS2data_i, Imm_i, RS1addr_i, RS2addr_i, RDaddr_i,
    input  RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, ALUdata_o, WriteData_o, RegAddr_o
  );

  modport slave (
    input  RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, ALUCtrl_i, ALUSrc_i,
           RS1data_i, RS2data_i, Imm_i, RS1addr_i, RS2addr_i, RDaddr_i,
    output RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, ALUdata_o, WriteData_o, RegAddr_o
  );
endinterface

// File: rtl/ex_stage_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per step, low DATA_W product bits kept.
// Sequencing (when to load, when to step) is owned by the EX stage controller.
module ex_mul_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              last_o,
  output logic [DATA_W-1:0] product_o
);
  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;
  logic [CW-1:0]     cnt_q;

  assign acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign last_o    = (cnt_q == CW'(DATA_W - 1));
  assign product_o = acc_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (load_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step_i) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_d;
      cnt_q    <= cnt_q + CW'(1);
    end
  end
endmodule

// File: rtl/ex_stage.sv
// EX pipeline stage: operand forwarding, single-cycle ALU, iterative MUL control
// and the EX/MEM register. Stalls upstream while a MUL is in flight.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              mem_stall_i,
  input  logic              MEMWB_RegWrite_i,
  input  logic [REG_AW-1:0] MEMWB_RDaddr_i,
  input  logic [DATA_W-1:0] MEMWB_data_i,
  ex_stage_if.slave         bus,
  output logic              ex_stall_o,
  output mul_state_e        state_o
);
  localparam int SHW = $clog2(DATA_W);

  mul_state_e        state_q;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] ex_res;
  logic [DATA_W-1:0] product;
  logic              mul_last;
  logic              issue_mul;
  logic              exmem_fwd_ok;
  logic              memwb_fwd_ok;

  // A load result is not yet in EX/MEM's ALUdata, so only non-load writers forward from there.
  assign exmem_fwd_ok = bus.RegWrite_o && !bus.MemToReg_o && (bus.RegAddr_o != '0);
  assign memwb_fwd_ok = MEMWB_RegWrite_i && (MEMWB_RDaddr_i != '0);

  always_comb begin
    fwd_a = bus.RS1data_i;
    if (exmem_fwd_ok && (bus.RegAddr_o == bus.RS1addr_i))
      fwd_a = bus.ALUdata_o;
    else if (memwb_fwd_ok && (MEMWB_RDaddr_i == bus.RS1addr_i))
      fwd_a = MEMWB_data_i;
  end

  always_comb begin
    fwd_b = bus.RS2data_i;
    if (exmem_fwd_ok && (bus.RegAddr_o == bus.RS2addr_i))
      fwd_b = bus.ALUdata_o;
    else if (memwb_fwd_ok && (MEMWB_RDaddr_i == bus.RS2addr_i))
      fwd_b = MEMWB_data_i;
  end

  assign op_b = bus.ALUSrc_i ? bus.Imm_i : fwd_b;

  always_comb begin
    alu_res = '0;
    case (bus.ALUCtrl_i)
      ALU_ADD: alu_res = fwd_a + op_b;
      ALU_SUB: alu_res = fwd_a - op_b;
      ALU_AND: alu_res = fwd_a & op_b;
      ALU_OR:  alu_res = fwd_a | op_b;
      ALU_XOR: alu_res = fwd_a ^ op_b;
      ALU_SLL: alu_res = fwd_a << op_b[SHW-1:0];
      ALU_SRL: alu_res = fwd_a >> op_b[SHW-1:0];
      ALU_SRA: alu_res = $signed(fwd_a) >>> op_b[SHW-1:0];
      ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
      default: alu_res = '0;
    endcase
  end

  // Stall is raised in the issue cycle itself so the MUL is never committed as an ALU result.
  assign issue_mul  = start_i && (state_q == ST_IDLE) && (bus.ALUCtrl_i == ALU_MUL);
  assign ex_stall_o = rst_i && (issue_mul || (state_q == ST_BUSY));
  assign ex_res     = (state_q == ST_DONE) ? product : alu_res;
  assign state_o    = state_q;

  ex_mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (issue_mul),
    .step_i   (start_i && (state_q == ST_BUSY)),
    .a_i      (fwd_a),
    .b_i      (op_b),
    .last_o   (mul_last),
    .product_o(product)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (issue_mul) state_q <= ST_BUSY;
        ST_BUSY: if (start_i && mul_last) state_q <= ST_DONE;
        ST_DONE: if (start_i && !mem_stall_i) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bus.RegWrite_o  <= 1'b0;
      bus.MemToReg_o  <= 1'b0;
      bus.MemRead_o   <= DMEM_NOAC;
      bus.MemWrite_o  <= DMEM_NOAC;
      bus.ALUdata_o   <= '0;
      bus.WriteData_o <= '0;
      bus.RegAddr_o   <= '0;
    end else if (start_i && !mem_stall_i) begin
      if (ex_stall_o) begin
        bus.RegWrite_o  <= 1'b0;
        bus.MemToReg_o  <= 1'b0;
        bus.MemRead_o   <= DMEM_NOAC;
        bus.MemWrite_o  <= DMEM_NOAC;
        bus.ALUdata_o   <= '0;
        bus.WriteData_o <= '0;
        bus.RegAddr_o   <= '0;
      end else begin
        bus.RegWrite_o  <= bus.RegWrite_i;
        bus.MemToReg_o  <= bus.MemToReg_i;
        bus.MemRead_o   <= bus.MemRead_i;
        bus.MemWrite_o  <= bus.MemWrite_i;
        bus.ALUdata_o   <= ex_res;
        bus.WriteData_o <= fwd_b;
        bus.RegAddr_o   <= bus.RDaddr_i;
      end
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios plus randomized ALU traffic checked
// against an arithmetic reference of the EX/MEM register contents.
module tb_ex_stage;
  import ex_stage_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct {
    logic          rw;
    logic          mtr;
    logic [1:0]    mr;
    logic [1:0]    mw;
    logic [3:0]    op;
    logic          src;
    logic [DW-1:0] d1, d2, imm;
    logic [AW-1:0] a1, a2, rd;
  } instr_t;

  logic          clk = 1'b0;
  logic          rst_n, start, mem_stall, wb_rw, ex_stall;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  mul_state_e    state;

  int errors = 0;
  int checks = 0;

  // reference EX/MEM register contents
  logic          m_rw, m_mtr;
  logic [1:0]    m_mr, m_mw;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_data, m_wd;
  logic [DW-1:0] exp_q[$];

  ex_stage_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

  ex_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk_i           (clk),
    .rst_i           (rst_n),
    .start_i         (start),
    .mem_stall_i     (mem_stall),
    .MEMWB_RegWrite_i(wb_rw),
    .MEMWB_RDaddr_i  (wb_rd),
    .MEMWB_data_i    (wb_data),
    .bus             (bus.slave),
    .ex_stall_o      (ex_stall),
    .state_o         (state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] ref_alu(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [4:0]        sh;
    logic [DW-1:0]     r, ones;
    int                sa, sb;
    longint unsigned   p;
    sh = b[4:0];
    ones = '1;
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLL: return a << sh;
      ALU_SRL: return a >> sh;
      ALU_SRA: begin
        r = a >> sh;
        if (a[DW-1]) r = r | ~(ones >> sh);
        return r;
      end
      ALU_SLT: begin
        sa = a; sb = b;
        return (sa < sb) ? 32'd1 : 32'd0;
      end
      ALU_MUL: begin
        p = {32'd0, a} * {32'd0, b};
        return p[31:0];
      end
      default: return '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] fwd(input logic [AW-1:0] addr, input logic [DW-1:0] rf);
    if (m_rw && !m_mtr && m_rd != 0 && m_rd == addr) return m_data;
    if (wb_rw && wb_rd != 0 && wb_rd == addr) return wb_data;
    return rf;
  endfunction

  function automatic logic [10:0] exp_ctrl();
    return {m_rw, m_mtr, m_mr, m_mw, m_rd};
  endfunction

  function automatic logic [10:0] act_ctrl();
    return {bus.RegWrite_o, bus.MemToReg_o, bus.MemRead_o, bus.MemWrite_o, bus.RegAddr_o};
  endfunction

  function automatic instr_t mk(input logic [3:0] op, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                input logic [AW-1:0] a2, input logic [DW-1:0] d2, input logic [AW-1:0] rd);
    instr_t i;
    i.rw = 1'b1; i.mtr = 1'b0; i.mr = 2'd0; i.mw = 2'd0; i.op = op; i.src = 1'b0; i.imm = '0;
    i.a1 = a1; i.d1 = d1; i.a2 = a2; i.d2 = d2; i.rd = rd;
    return i;
  endfunction

  task automatic model_clear();
    m_rw = 0; m_mtr = 0; m_mr = 0; m_mw = 0; m_rd = 0; m_data = 0; m_wd = 0;
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input instr_t i);
    bus.RegWrite_i = i.rw;  bus.MemToReg_i = i.mtr; bus.MemRead_i = i.mr; bus.MemWrite_i = i.mw;
    bus.ALUCtrl_i  = i.op;  bus.ALUSrc_i   = i.src; bus.Imm_i     = i.imm;
    bus.RS1data_i  = i.d1;  bus.RS2data_i  = i.d2;
    bus.RS1addr_i  = i.a1;  bus.RS2addr_i  = i.a2;  bus.RDaddr_i  = i.rd;
  endtask

  // single-cycle instruction; called at a negedge, returns at the next negedge
  task automatic issue(input instr_t i);
    logic [DW-1:0] ea, eb, res;
    drive(i);
    ea  = fwd(i.a1, i.d1);
    eb  = fwd(i.a2, i.d2);
    res = ref_alu(i.op, ea, i.src ? i.imm : eb);
    @(posedge clk);
    m_rw = i.rw; m_mtr = i.mtr; m_mr = i.mr; m_mw = i.mw; m_rd = i.rd; m_data = res; m_wd = eb;
    exp_q.push_back(res);
    @(negedge clk);
  endtask

  // MUL issue through commit; hold>0 raises mem_stall near the end of BUSY for hold edges
  task automatic mul_run(input instr_t i, input int hold, output int stall_cnt, output int bubble_bad,
                         output int hold_bad, output logic issue_stall, output logic timed_out);
    logic [DW-1:0] ea, eb, prod, wd;
    int ms_edges;
    drive(i);
    ea   = fwd(i.a1, i.d1);
    eb   = fwd(i.a2, i.d2);
    prod = ref_alu(ALU_MUL, ea, i.src ? i.imm : eb);
    #1 issue_stall = ex_stall;
    stall_cnt = 1; bubble_bad = 0; hold_bad = 0; timed_out = 1'b1; ms_edges = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      if (mem_stall) ms_edges++;
      @(negedge clk);
      if (k == 0) model_clear();
      if (!ex_stall) begin timed_out = 1'b0; break; end
      stall_cnt++;
      if (bus.RegWrite_o !== 1'b0 || bus.ALUdata_o !== '0) bubble_bad++;
      if (hold > 0 && stall_cnt == 32) mem_stall = 1'b1;
    end
    if (hold > 0) mem_stall = 1'b1;
    for (int k = 0; k < 20 && ms_edges < hold; k++) begin
      if (ex_stall !== 1'b0 || state !== ST_DONE || bus.RegWrite_o !== 1'b0 || bus.ALUdata_o !== '0)
        hold_bad++;
      @(posedge clk);
      ms_edges++;
      @(negedge clk);
    end
    mem_stall = 1'b0;
    wd = fwd(i.a2, i.d2);
    @(posedge clk);
    m_rw = i.rw; m_mtr = i.mtr; m_mr = i.mr; m_mw = i.mw; m_rd = i.rd; m_data = prod; m_wd = wd;
    exp_q.push_back(prod);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.ALUdata_o !== '0) begin errors++; $display("FAIL reset_aludata: got %h want 0", bus.ALUdata_o); end
    checks++; if (bus.WriteData_o !== '0) begin errors++; $display("FAIL reset_wdata: got %h want 0", bus.WriteData_o); end
    checks++; if (act_ctrl() !== 11'd0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", act_ctrl()); end
    checks++; if (ex_stall !== 1'b0 || state !== ST_IDLE) begin errors++; $display("FAIL reset_fsm: stall=%b state=%0d want 0/IDLE", ex_stall, state); end
    model_clear();
    rst_n = 1'b1; start = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_forward_add();
    instr_t i;
    issue(mk(ALU_ADD, 5'd4, 32'd5, 5'd5, 32'd7, 5'd1));
    checks++; if (bus.ALUdata_o !== 32'd12) begin errors++; $display("FAIL add_basic: got %h want %h", bus.ALUdata_o, 32'd12); end
    i = mk(ALU_ADD, 5'd1, 32'd0, 5'd0, 32'd0, 5'd2);
    i.src = 1'b1; i.imm = 32'd3;
    issue(i);
    checks++; if (bus.ALUdata_o !== 32'd15) begin errors++; $display("FAIL add_exmem_fwd: got %h want %h", bus.ALUdata_o, 32'd15); end
    checks++; if (act_ctrl() !== {1'b1, 1'b0, 2'd0, 2'd0, 5'd2}) begin errors++; $display("FAIL add_ctrl: got %h", act_ctrl()); end
    exp_q.delete();
  endtask

  task automatic test_alu_edges();
    instr_t i;
    i = mk(ALU_SRA, 5'd0, 32'h8000_0000, 5'd0, 32'd0, 5'd6);
    i.src = 1'b1; i.imm = 32'd4;
    issue(i);
    checks++; if (bus.ALUdata_o !== 32'hF800_0000) begin errors++; $display("FAIL sra: got %h want %h", bus.ALUdata_o, 32'hF800_0000); end
    issue(mk(ALU_SLT, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd1, 5'd7));
    checks++; if (bus.ALUdata_o !== 32'd1) begin errors++; $display("FAIL slt: got %h want 1", bus.ALUdata_o); end
    issue(mk(ALU_SUB, 5'd0, 32'd0, 5'd0, 32'd1, 5'd8));
    checks++; if (bus.ALUdata_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub: got %h want ffffffff", bus.ALUdata_o); end
    exp_q.delete();
  endtask

  task automatic test_x0_priority();
    issue(mk(ALU_ADD, 5'd0, 32'd9, 5'd0, 32'd0, 5'd0));
    wb_rw = 1'b1; wb_rd = 5'd0; wb_data = 32'd9;
    issue(mk(ALU_ADD, 5'd0, 32'd0, 5'd0, 32'd0, 5'd11));
    checks++; if (bus.ALUdata_o !== 32'd0) begin errors++; $display("FAIL x0_no_fwd: got %h want 0", bus.ALUdata_o); end
    issue(mk(ALU_ADD, 5'd0, 32'd1, 5'd0, 32'd0, 5'd3));
    wb_rd = 5'd3; wb_data = 32'd2;
    issue(mk(ALU_ADD, 5'd3, 32'd0, 5'd3, 32'd0, 5'd9));
    checks++; if (bus.ALUdata_o !== 32'd2) begin errors++; $display("FAIL exmem_priority: got %h want 2", bus.ALUdata_o); end
    checks++; if (bus.WriteData_o !== 32'd1) begin errors++; $display("FAIL exmem_priority_wdata: got %h want 1", bus.WriteData_o); end
    issue(mk(ALU_ADD, 5'd3, 32'd0, 5'd0, 32'd0, 5'd12));
    checks++; if (bus.ALUdata_o !== 32'd2) begin errors++; $display("FAIL memwb_fwd: got %h want 2", bus.ALUdata_o); end
    wb_rw = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_mul();
    int sc, bb, hb; logic is, to;
    instr_t i;
    mul_run(mk(ALU_MUL, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd3, 5'd10), 0, sc, bb, hb, is, to);
    checks++; if (is !== 1'b1) begin errors++; $display("FAIL mul_issue_stall: got %b want 1", is); end
    checks++; if (to) begin errors++; $display("FAIL mul_timeout: stall never dropped"); end
    checks++; if (sc != 33) begin errors++; $display("FAIL mul_stall_cycles: got %0d want 33", sc); end
    checks++; if (bb != 0) begin errors++; $display("FAIL mul_bubbles: %0d non-bubble cycles, want 0", bb); end
    checks++; if (bus.ALUdata_o !== 32'hFFFF_FFFD) begin errors++; $display("FAIL mul_product: got %h want fffffffd", bus.ALUdata_o); end
    checks++; if (act_ctrl() !== {1'b1, 1'b0, 2'd0, 2'd0, 5'd10}) begin errors++; $display("FAIL mul_ctrl: got %h", act_ctrl()); end
    checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL mul_idle: state=%0d want IDLE", state); end
    i = mk(ALU_ADD, 5'd10, 32'd0, 5'd0, 32'd0, 5'd13);
    i.src = 1'b1; i.imm = 32'd5;
    issue(i);
    checks++; if (bus.ALUdata_o !== 32'd2) begin errors++; $display("FAIL mul_fwd: got %h want 2", bus.ALUdata_o); end
    exp_q.delete();
  endtask

  task automatic test_mul_mem_stall();
    int sc, bb, hb; logic is, to;
    logic [DW-1:0] a, b, want;
    a = $urandom(); b = $urandom();
    want = ref_alu(ALU_MUL, a, b);
    mul_run(mk(ALU_MUL, 5'd0, a, 5'd0, b, 5'd15), 5, sc, bb, hb, is, to);
    checks++; if (to || sc != 33) begin errors++; $display("FAIL mulst_stall_cycles: got %0d timeout=%b want 33", sc, to); end
    checks++; if (hb != 0) begin errors++; $display("FAIL mulst_done_hold: %0d bad hold cycles, want 0", hb); end
    checks++; if (bus.ALUdata_o !== want) begin errors++; $display("FAIL mulst_product: got %h want %h", bus.ALUdata_o, want); end
    exp_q.delete();
  endtask

  task automatic test_stall_hold();
    logic [DW-1:0] old_data;
    logic [10:0]   old_ctrl;
    old_data = m_data; old_ctrl = exp_ctrl();
    drive(mk(ALU_ADD, 5'd0, 32'h1111, 5'd0, 32'h2222, 5'd14));
    mem_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin mem_stall = 1'b0; start = 1'b0; end
      @(posedge clk); @(negedge clk);
      checks++;
      if (bus.ALUdata_o !== old_data || act_ctrl() !== old_ctrl) begin
        errors++; $display("FAIL hold_%0d: got %h/%h want %h/%h", k, bus.ALUdata_o, act_ctrl(), old_data, old_ctrl);
      end
    end
    start = 1'b1;
    issue(mk(ALU_ADD, 5'd0, 32'h1111, 5'd0, 32'h2222, 5'd14));
    checks++; if (bus.ALUdata_o !== 32'h3333) begin errors++; $display("FAIL hold_release: got %h want 3333", bus.ALUdata_o); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_mul();
    drive(mk(ALU_MUL, 5'd0, 32'd1234, 5'd0, 32'd5678, 5'd16));
    repeat (11) begin @(posedge clk); @(negedge clk); end
    checks++; if (state !== ST_BUSY) begin errors++; $display("FAIL rstmul_busy: state=%0d want BUSY", state); end
    rst_n = 1'b0;
    #1;
    checks++; if (ex_stall !== 1'b0 || state !== ST_IDLE) begin errors++; $display("FAIL rstmul_fsm: stall=%b state=%0d want 0/IDLE", ex_stall, state); end
    checks++; if (act_ctrl() !== 11'd0 || bus.ALUdata_o !== '0 || bus.WriteData_o !== '0) begin errors++; $display("FAIL rstmul_exmem: ctrl=%h data=%h", act_ctrl(), bus.ALUdata_o); end
    drive(mk(ALU_ADD, 5'd0, 32'd100, 5'd0, 32'd23, 5'd17));
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    issue(mk(ALU_ADD, 5'd0, 32'd100, 5'd0, 32'd23, 5'd17));
    checks++; if (bus.ALUdata_o !== 32'd123) begin errors++; $display("FAIL rstmul_add: got %h want %h", bus.ALUdata_o, 32'd123); end
    exp_q.delete();
  endtask

  task automatic test_random();
    instr_t i;
    logic [DW-1:0] want;
    exp_q.delete();
    for (int n = 0; n < 40; n++) begin
      i = mk(4'($urandom_range(0, 8)), 5'($urandom_range(0, 3)), $urandom(),
             5'($urandom_range(0, 3)), $urandom(), 5'($urandom_range(0, 3)));
      i.rw  = 1'($urandom_range(0, 1));
      i.mtr = ($urandom_range(0, 3) == 0);
      i.mr  = 2'($urandom_range(0, 3));
      i.mw  = 2'($urandom_range(0, 3));
      i.src = 1'($urandom_range(0, 1));
      i.imm = $urandom();
      wb_rw = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 3)); wb_data = $urandom();
      issue(i);
      want = exp_q.pop_front();
      checks++; if (bus.ALUdata_o !== want) begin errors++; $display("FAIL rnd%0d_data: op=%0d got %h want %h", n, i.op, bus.ALUdata_o, want); end
      checks++; if (bus.WriteData_o !== m_wd) begin errors++; $display("FAIL rnd%0d_wdata: got %h want %h", n, bus.WriteData_o, m_wd); end
      checks++; if (act_ctrl() !== exp_ctrl() || ex_stall !== 1'b0) begin errors++; $display("FAIL rnd%0d_ctrl: got %h stall=%b want %h", n, act_ctrl(), ex_stall, exp_ctrl()); end
    end
    wb_rw = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mem_stall = 1'b0;
    wb_rw = 1'b0; wb_rd = '0; wb_data = '0;
    drive(mk(ALU_ADD, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0));
    model_clear();
    @(negedge clk);
    test_reset();
    test_forward_add();
    test_alu_edges();
    test_x0_priority();
    test_mul();
    test_mul_mem_stall();
    test_stall_hold();
    test_reset_mid_mul();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
